// File: rtl/multiword_adder_ctrl_pkg.sv
// Shared definitions for the multi-word adder controller: the nibble width
// that the external ripple-carry adder works on, and the controller state
// encoding. Imported by the interface, the shifter and the top level.
package multiword_adder_ctrl_pkg;

    // Width of one slice handled by the external adder per cycle
    localparam int NIB_W = 4;

    // Controller states: waiting, stepping through nibbles, one-cycle result strobe
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwadd_state_e;

endpackage

// File: rtl/multiword_adder_ctrl_if.sv
// Request/response bundle between a requester and the multi-word adder
// controller. The requester (master) presents operands and a start strobe;
// the controller (slave) returns the assembled result and status flags.
interface multiword_adder_ctrl_if
    import multiword_adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4
);

    localparam int W = NIB_W * WORDS;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         carry_in;
    logic         sub;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, op_a, op_b, carry_in, sub,
        input  result, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, op_a, op_b, carry_in, sub,
        output result, carry_out, overflow, busy, done
    );

endinterface

// File: rtl/multiword_adder_ctrl_nibble_shifter.sv
// Parallel-load register that shifts right by one nibble per enabled cycle,
// inserting a new nibble at the top. Used for the A and B operand streams
// (which drain their low nibble into the adder) and for result assembly
// (which collects adder sums from the top down).
module nibble_shifter
    import multiword_adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4,
    localparam int W = NIB_W * WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic [NIB_W-1:0] nib_i,
    output logic [W-1:0]     q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Load wins over shift; the controller never requests both in one cycle
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = {nib_i, data_q[W-1:NIB_W]};
        end
    end

    // Register the word; reset clears it so the adder sees zeros afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Multi-word adder controller: adds two WORDS x 4-bit operands one nibble
// per cycle through an external 4-bit ripple-carry adder, chaining the carry
// between nibbles and assembling the full-width result.
// Optional feature macro: MWADD_SUB_EN enables subtraction via the sub input.
module multiword_adder_ctrl
    import multiword_adder_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multiword_adder_ctrl_if.slave bus,
    output logic [NIB_W-1:0]     add_a_o,
    output logic [NIB_W-1:0]     add_b_o,
    output logic                 add_cin_o,
    input  logic [NIB_W-1:0]     add_sum_i,
    input  logic                 add_cout_i
);

    localparam int W  = NIB_W * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    mwadd_state_e  state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          shiftEn;
    logic [W-1:0]  bEff;
    logic          cinEff;
    logic [W-1:0]  aWord;
    logic [W-1:0]  bWord;

    // Effective B operand and initial carry: invert B and force carry for subtract
`ifdef MWADD_SUB_EN
    always_comb begin
        bEff   = bus.sub ? ~bus.op_b : bus.op_b;
        cinEff = bus.sub ? 1'b1 : bus.carry_in;
    end
`else
    // Without subtract support the sub pin is kept for compatibility but has no effect
    always_comb begin
        bEff   = bus.op_b;
        cinEff = bus.carry_in ^ (bus.sub & 1'b0);
    end
`endif

    // Next-state logic: accept in IDLE/DONE, step nibbles in RUN, latch final flags on the last nibble
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        shiftEn = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    idx_d   = '0;
                    carry_d = cinEff;
                end
            end
            RUN: begin
                shiftEn = 1'b1;
                carry_d = add_cout_i;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = add_cout_i;
                    ovf_d   = (add_a_o[NIB_W-1] == add_b_o[NIB_W-1]) &&
                              (add_sum_i[NIB_W-1] != add_a_o[NIB_W-1]);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    nibble_shifter #(.WORDS(WORDS)) u_shiftA (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (bus.op_a),
        .shift_i    (shiftEn),
        .nib_i      ('0),
        .q_o        (aWord)
    );

    nibble_shifter #(.WORDS(WORDS)) u_shiftB (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (bEff),
        .shift_i    (shiftEn),
        .nib_i      ('0),
        .q_o        (bWord)
    );

    nibble_shifter #(.WORDS(WORDS)) u_shiftRes (
        .clk        (clk),
        .rst        (rst),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (shiftEn),
        .nib_i      (add_sum_i),
        .q_o        (bus.result)
    );

    assign add_a_o       = aWord[NIB_W-1:0];
    assign add_b_o       = bWord[NIB_W-1:0];
    assign add_cin_o     = carry_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);

endmodule

// File: doc/multiword_adder_ctrl.md
# multiword_adder_ctrl

Sequential controller that adds two WORDS×4-bit operands one nibble per cycle on the team's existing 4-bit ripple-carry adder. It sits directly upstream and downstream of that adder: it drives the adder's `a`, `b` and `carry_in` from registered operand shifters, and consumes `sum` and `carry_out`. It chains the carry between nibbles and assembles the full-width result. Wide additions thus reuse one small adder at the cost of WORDS cycles.

## Interface
Parameters:
- `WORDS`, default 4: number of 4-bit nibbles per operand (≥2); operand width W = 4·WORDS.

Ports:
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: request; sampled only in IDLE or DONE.
- `op_a` input, W: operand A, captured on accepted start.
- `op_b` input, W: operand B, captured on accepted start.
- `carry_in` input, 1: initial carry, captured on accepted start.
- `sub` input, 1: subtract request (see Configuration).
- `add_a` output, 4: nibble to adder `a`.
- `add_b` output, 4: nibble to adder `b`.
- `add_cin` output, 1: to adder `carry_in`.
- `add_sum` input, 4: from adder `sum`.
- `add_cout` input, 1: from adder `carry_out`.
- `result` output, W: assembled sum.
- `carry_out` output, 1: final carry.
- `overflow` output, 1: signed overflow of the W-bit operation.
- `busy` output, 1: high in RUN.
- `done` output, 1: high in DONE (one cycle).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Accept: `start`=1 at an edge in IDLE or DONE. On that edge:
  - load A shifter ← `op_a` and B shifter ← effective B;
  - carry register ← effective carry-in;
  - nibble index ← 0; state → RUN.
- Adder drive: `add_a` = A shifter [3:0], `add_b` = B shifter [3:0], `add_cin` = carry register. All three are purely registered, with no combinational input-to-output path.
- RUN, each edge:
  - result register shifts right 4, with `add_sum` inserted at [W-1:W-4];
  - A and B shifters shift right 4;
  - carry register ← `add_cout`; index += 1.
- On the edge where index = WORDS-1:
  - state → DONE;
  - `carry_out` ← `add_cout`;
  - `overflow` ← (A[W-1] == Beff[W-1]) && (`add_sum`[3] != A[W-1]), using the MSB nibble values presented that cycle.
- DONE lasts exactly one cycle, then → IDLE unless a new start is accepted.
- `result`, `carry_out` and `overflow` hold their values in DONE and IDLE until the next accepted start. After an accepted start, `result` is undefined-in-progress until `done`.
- `start` during RUN is ignored; no queuing.
- Arithmetic: `result` = (A + Beff + cin) mod 2^W; `carry_out` = bit W of the exact sum.

## Timing
- Reset values: `add_a`=0, `add_b`=0, `add_cin`=0, `result`=0, `carry_out`=0, `overflow`=0, `busy`=0, `done`=0; state IDLE; index 0.
- Reset mid-RUN aborts immediately with the values above. No partial result is retained.
- Let the start accept edge be E0:
  - `busy` is high from after E0 through E(WORDS);
  - `done` is high in the cycle after edge E(WORDS);
  - latency is WORDS cycles from accept to `done`.
- Back-to-back: `start` high during the DONE cycle is accepted at that edge. `done` falls, `busy` rises, and throughput is one operation per WORDS cycles.
- The adder is combinational between `add_*` outputs and `add_sum`/`add_cout`. Its ripple delay plus result-register setup must fit in one `clk` period.

## Configuration
- Macro `MWADD_SUB_EN`:
  - **Defined:** when `sub`=1 at accept, Beff = ~`op_b` and the effective carry-in is forced to 1, so `result` = A − B. `carry_out`=1 means no borrow, and `overflow` is the signed-subtract overflow. When `sub`=0, the block behaves as a plain add.
  - **Undefined:** the `sub` port remains present but is ignored. Beff = `op_b` and the effective carry-in = `carry_in`.

## Structure
- Shared package: state encoding enum (IDLE/RUN/DONE) and the nibble-width constant (4).
- One natural sub-module, `nibble_shifter`: a W-bit parallel-load, shift-right-by-4 register with an enable. It is instantiated three times, for A, B and the result (the result instance uses a serial nibble input at the top).
- The 4-bit adder is instantiated by the parent, not inside this block. The bench instantiates both.

## Test plan
WORDS=4 unless stated.
- **Plain add with carry ripple:** 0x00FF + 0x0001, `carry_in`=0 → `result`=0x0100, `carry_out`=0, `overflow`=0. `done` is high exactly 4 cycles after accept, and `busy` is high for those 4 cycles.
- **Full carry chain and overflow:** 0xFFFF + 0x0000, `carry_in`=1 → `result`=0x0000, `carry_out`=1. Separately, 0x7FFF + 0x0001 → 0x8000, `overflow`=1.
- **Subtract (`MWADD_SUB_EN` defined):**
  - 0x0005 − 0x0007 with `sub`=1 → `result`=0xFFFE, `carry_out`=0.
  - 0x8000 − 0x0001 → 0x7FFF, `overflow`=1.
  - With the macro undefined, the same stimulus gives 0x000C.
- **Back-to-back and ignored start:** start held through RUN is ignored. Start during DONE is accepted, and the second result 0x1234 + 0x1111 = 0x2345 appears 4 cycles later.
- **Reset mid-operation:** assert `rst` at RUN index 2 → all outputs 0 asynchronously and state IDLE. A new start after release gives a correct result.
- **WORDS=2:** 0xF0 + 0x20 → `result`=0x10, `carry_out`=1, with 2-cycle latency.
